// File: rtl/modexp_pkg.sv
// modexp_pkg: shared state encoding and width helpers for the modular exponentiation engine.
package modexp_pkg;
  typedef enum logic [1:0] {IDLE, REDUCE, STEP, DONE} state_t;
  localparam int W_DEF = 8;
  localparam int CNT_W = $clog2(W_DEF + 1);
  localparam int MUL_W = W_DEF + 2;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  function automatic int mul_w(input int w);
    return w + 2;
  endfunction
endpackage

// File: rtl/modexp_engine_modmul.sv
// modmul_serial: r = x*y mod m, interleaved shift-add over y from its MSB, one bit per cycle.
module modmul_serial import modexp_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] m,
  output logic         done,
  output logic [W-1:0] r
);
  localparam int CW = cnt_w(W);
  localparam int MW = mul_w(W);
  logic [W-1:0] rr, xr, mr, ys, cur, xv, mv;
  logic [CW-1:0] cnt;
  logic [MW-1:0] t;
  logic yb;
  // the start edge already performs the first bit, so the whole product takes W edges
  always_comb begin
    cur = start ? '0 : rr;
    xv = start ? x : xr;
    mv = start ? m : mr;
    yb = start ? y[W-1] : ys[W-1];
    t = {1'b0, cur, 1'b0} + (yb ? MW'(xv) : '0);
    t = t >= MW'(mv) ? t - MW'(mv) : t;
    t = t >= MW'(mv) ? t - MW'(mv) : t;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) {rr, xr, mr, ys, cnt, done} <= '0;
    else if (clear) {rr, xr, mr, ys, cnt, done} <= '0;
    else if (start) begin
      rr <= t[W-1:0];
      xr <= x;
      mr <= m;
      ys <= y << 1;
      cnt <= CW'(W - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      rr <= t[W-1:0];
      ys <= ys << 1;
      cnt <= cnt - 1'b1;
      done <= cnt == CW'(1);
    end else done <= 1'b0;
  assign r = rr;
endmodule

// File: rtl/modexp_engine.sv
// modexp_engine: result = base^exp mod mod, LSB-first square-and-multiply with early termination,
// valid/ready on both sides and an error flag for a zero modulus.
module modexp_engine import modexp_pkg::*; #(
  parameter int W = 8,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     base,
  input  logic [EXP_W-1:0] exp,
  input  logic [W-1:0]     mod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             err
);
  state_t state;
  logic go, adv, last, a_start, s_start, a_done, s_done;
  logic [W-1:0] b, m, acc, a_r, s_r, a_x, a_y, b_n, acc_n;
  logic [EXP_W-1:0] e;
  assign in_ready = state == IDLE;
  assign b_n = state == REDUCE ? a_r : s_r;
  assign acc_n = state == REDUCE ? (m == W'(1) ? '0 : W'(1)) : (e[0] ? a_r : acc);
  assign last = state == REDUCE ? e == '0 : (e >> 1) == '0;
  assign adv = a_done && (state == REDUCE || s_done);
  assign s_start = adv && !last;
  // mul_a first reduces the raw base (1*base), then serves as the acc*b multiplier
  assign a_start = (go && m != '0) || s_start;
  assign a_x = go ? W'(1) : acc_n;
  assign a_y = go ? b : b_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {go, b, e, m, acc, out_valid, result, err} <= '0;
    end else if (clear) begin
      state <= IDLE;
      {go, b, e, m, acc, out_valid, result, err} <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          state <= REDUCE;
          go <= 1'b1;
          b <= base;
          e <= exp;
          m <= mod;
        end
        REDUCE, STEP: begin
          go <= 1'b0;
          if (m == '0) begin
            state <= DONE;
            out_valid <= 1'b1;
            err <= 1'b1;
            result <= '0;
          end else if (adv) begin
            b <= b_n;
            acc <= acc_n;
            if (state == STEP) e <= e >> 1;
            state <= last ? DONE : STEP;
            out_valid <= last;
            if (last) result <= acc_n;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  modmul_serial #(.W(W)) mul_a (
    .clk(clk), .reset(reset), .clear(clear), .start(a_start),
    .x(a_x), .y(a_y), .m(m), .done(a_done), .r(a_r)
  );
  modmul_serial #(.W(W)) mul_s (
    .clk(clk), .reset(reset), .clear(clear), .start(s_start),
    .x(b_n), .y(b_n), .m(m), .done(s_done), .r(s_r)
  );
endmodule

// File: tb/tb_modexp_engine.sv
// tb_modexp_engine: arithmetic reference model with a per-cycle compare process plus directed literal checks.
module tb_modexp_engine;
  logic clk, reset, clear, in_valid, in_ready, out_valid, out_ready, err;
  logic [7:0] base, exp, mod, result;
  int n_chk = 0, n_fail = 0, n_hs = 0;
  int active = 0, t = 0, lat = 0, want_res = 0, want_err = 0;
  int last_res, last_err, last_lat;

  modexp_engine #(.W(8), .EXP_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .exp(exp), .mod(mod), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int model_res(input int b, input int e, input int m);
    longint r;
    if (m == 0) return 0;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return int'(r);
  endfunction

  function automatic int model_lat(input int e, input int m);
    int k = 0;
    if (m == 0) return 1;
    while ((e >> k) != 0) k++;
    return 8 * (1 + k) + 1;
  endfunction

  always @(negedge clk) begin
    if (!reset) active = 0;
    if (active != 0) t++;
    check("in_ready", 32'(in_ready), 32'(active == 0));
    check("out_valid", 32'(out_valid), 32'(active != 0 && t >= lat));
    if (out_valid) begin
      check("result", 32'(result), 32'(want_res));
      check("err", 32'(err), 32'(want_err));
    end
    if (!reset || clear) active = 0;
    else if (active != 0 && out_valid && out_ready) begin
      active = 0;
      n_hs++;
    end else if (active == 0 && in_valid && in_ready) begin
      active = 1;
      t = -1;
      lat = model_lat(int'(exp), int'(mod));
      want_res = model_res(int'(base), int'(exp), int'(mod));
      want_err = int'(mod == 0);
    end
  end

  task automatic start(input int b, input int e, input int m, input logic rdy);
    @(posedge clk);
    #1;
    base = 8'(b);
    exp = 8'(e);
    mod = 8'(m);
    out_ready = rdy;
    in_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic finish_job(input bit stall);
    int hs0 = n_hs;
    last_lat = -1;
    for (int i = 0; i < 400 && last_lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) last_lat = i;
    end
    check("done_timeout", 32'(last_lat >= 0), 32'd1);
    last_res = int'(result);
    last_err = int'(err);
    if (stall) begin
      repeat (20) @(posedge clk);
      #1 out_ready = 1;
    end
    for (int i = 0; i < 50 && n_hs == hs0; i++) @(negedge clk);
    check("handshake_count", 32'(n_hs - hs0), 32'd1);
  endtask

  task automatic job(input int b, input int e, input int m, input bit stall);
    start(b, e, m, !stall);
    finish_job(stall);
  endtask

  task automatic abort_at_e10(input bit use_reset);
    start(200, 3, 255, 1);
    repeat (9) @(posedge clk);
    #1;
    if (use_reset) reset = 0;
    else clear = 1;
    @(posedge clk);
    #1;
    reset = 1;
    clear = 0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 0;
    clear = 0;
    in_valid = 0;
    out_ready = 1;
    base = 0;
    exp = 0;
    mod = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 reset = 1;
    job(3, 5, 7, 0);
    check("3^5%7_res", 32'(last_res), 32'd5);
    check("3^5%7_err", 32'(last_err), 32'd0);
    check("3^5%7_lat", 32'(last_lat), 32'd33);
    job(200, 3, 255, 0);
    check("200^3%255_res", 32'(last_res), 32'd140);
    check("200^3%255_lat", 32'(last_lat), 32'd25);
    job(2, 0, 13, 0);
    check("2^0%13_res", 32'(last_res), 32'd1);
    check("2^0%13_lat", 32'(last_lat), 32'd9);
    job(9, 0, 1, 0);
    check("9^0%1_res", 32'(last_res), 32'd0);
    job(5, 3, 0, 0);
    check("mod0_err", 32'(last_err), 32'd1);
    check("mod0_res", 32'(last_res), 32'd0);
    check("mod0_lat", 32'(last_lat), 32'd1);
    job(3, 5, 7, 1);
    check("stall_res", 32'(last_res), 32'd5);
    abort_at_e10(0);
    job(3, 5, 7, 0);
    check("after_clear_res", 32'(last_res), 32'd5);
    abort_at_e10(1);
    job(3, 5, 7, 0);
    check("after_reset_res", 32'(last_res), 32'd5);
    @(posedge clk);
    #1;
    base = 3;
    exp = 5;
    mod = 7;
    in_valid = 1;
    clear = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    clear = 0;
    repeat (12) @(negedge clk);
    check("clear_drop_in_ready", 32'(in_ready), 32'd1);
    check("clear_drop_out_valid", 32'(out_valid), 32'd0);
    job(13, 200, 97, 0);
    job(255, 255, 251, 0);
    job(7, 1, 2, 0);
    job(0, 5, 9, 0);
    job(1, 0, 1, 0);
    job(128, 128, 129, 0);
    job(250, 7, 3, 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
